// File: rtl/matriz_pkg.sv
// Shared types and constants for the LED matrix scan sequencer.
// Holds the FSM state encoding, default geometry and a counter-width helper.
package matriz_pkg;

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      VARRENDO = 2'd1,
      PAUSADO  = 2'd2
   } estado_t;

   localparam int ROWS_DEF = 7;
   localparam int COLS_DEF = 5;

   // Width needed to hold 0..n-1, never less than one bit.
   function automatic int largura(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/controle_matriz_if.sv
// Control and matrix-side signals of the scan sequencer.
// master drives en/pausa/avanca; slave (the sequencer) drives the registered outputs.
interface controle_matriz_if
   import matriz_pkg::*;
#(
   parameter int ROWS   = ROWS_DEF,
   parameter int FRAMES = 4
);
   logic                        en;
   logic                        pausa;
   logic                        avanca;
   logic [2:0]                  contador;
   logic [ROWS-1:0]             linhas;
   logic [largura(FRAMES)-1:0]  quadro_sel;
   logic                        blank;
   logic                        frame_tick;

   modport master (
      output en, pausa, avanca,
      input  contador, linhas, quadro_sel, blank, frame_tick
   );

   modport slave (
      input  en, pausa, avanca,
      output contador, linhas, quadro_sel, blank, frame_tick
   );
endinterface

// File: rtl/divisor_varredura.sv
// Row-period prescaler: counts 0..DIV-1 while enabled, clr forces 0.
// tc is high combinationally during the last count of each period.
module divisor_varredura
   import matriz_pkg::*;
#(
   parameter int DIV = 4
)(
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tc
);
   localparam int             CW   = largura(DIV);
   localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = en && (cnt_q == LAST);

endmodule

// File: rtl/controle_matriz.sv
// Row scan and frame sequencer for the LED matrix; every output is a flop.
// MATRIZ_BLANK_GUARD_EN blanks the first cycle of each row period against ghosting.
module controle_matriz
   import matriz_pkg::*;
#(
   parameter int SCAN_DIV   = 4,
   parameter int ROWS       = ROWS_DEF,
   parameter int FRAMES     = 4,
   parameter int FRAME_HOLD = 2
)(
   input logic               clk,
   input logic               rst_n,
   controle_matriz_if.slave  bus
);
   localparam int            RW = largura(ROWS);
   localparam int            QW = largura(FRAMES);
   localparam int            SW = largura(FRAME_HOLD);
   localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);
   localparam logic [QW-1:0] QUADRO_LAST = QW'(FRAMES - 1);
   localparam logic [SW-1:0] SCAN_LAST   = SW'(FRAME_HOLD - 1);

   estado_t         estado_q, estado_d;
   logic [RW-1:0]   row_q, row_d;
   logic [SW-1:0]   scan_q, scan_d;
   logic [QW-1:0]   quadro_q, quadro_d;
   logic [ROWS-1:0] linhas_q, linhas_d;
   logic            blank_q, blank_d;
   logic            tick_q, tick_d;
   logic            tc, wrap, passo;

   divisor_varredura #(.DIV(SCAN_DIV)) u_divisor (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (estado_q != OCIOSO),
      .clr   (estado_d == OCIOSO),
      .tc    (tc)
   );

   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         OCIOSO:   if (bus.en) estado_d = VARRENDO;
         VARRENDO: if (!bus.en) estado_d = OCIOSO;
                   else if (bus.pausa) estado_d = PAUSADO;
         PAUSADO:  if (!bus.en) estado_d = OCIOSO;
                   else if (!bus.pausa) estado_d = VARRENDO;
         default:  estado_d = OCIOSO;
      endcase
   end

   always_comb begin
      row_d    = row_q;
      scan_d   = scan_q;
      quadro_d = quadro_q;
      tick_d   = 1'b0;
      passo    = 1'b0;
      wrap     = tc && (row_q == ROW_LAST);
      if (estado_d == OCIOSO) begin
         row_d    = '0;
         scan_d   = '0;
         quadro_d = '0;
      end else begin
         if (tc) row_d = wrap ? '0 : row_q + RW'(1);
         // Scan count only moves in auto mode; a pause freezes it for resume.
         if (estado_q == VARRENDO && wrap) begin
            if (scan_q == SCAN_LAST) begin
               scan_d = '0;
               passo  = 1'b1;
            end else begin
               scan_d = scan_q + SW'(1);
            end
         end
         if (estado_q == PAUSADO && bus.avanca) passo = 1'b1;
         if (passo) begin
            quadro_d = (quadro_q == QUADRO_LAST) ? '0 : quadro_q + QW'(1);
            tick_d   = 1'b1;
         end
      end

      blank_d = (estado_q == OCIOSO) || (estado_d == OCIOSO);
`ifdef MATRIZ_BLANK_GUARD_EN
      blank_d = blank_d || tc;
`endif
      linhas_d = '1;
      if (!blank_d) linhas_d[row_d] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q <= OCIOSO;
         row_q    <= '0;
         scan_q   <= '0;
         quadro_q <= '0;
         linhas_q <= '1;
         blank_q  <= 1'b1;
         tick_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         row_q    <= row_d;
         scan_q   <= scan_d;
         quadro_q <= quadro_d;
         linhas_q <= linhas_d;
         blank_q  <= blank_d;
         tick_q   <= tick_d;
      end
   end

   assign bus.contador   = 3'(row_q);
   assign bus.linhas     = linhas_q;
   assign bus.quadro_sel = quadro_q;
   assign bus.blank      = blank_q;
   assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_controle_matriz.sv
// Directed bench for controle_matriz with default parameters; outputs sampled 1 time unit after each rising edge.
module tb_controle_matriz;
   localparam int SCAN_DIV   = 4;
   localparam int ROWS       = 7;
   localparam int FRAMES     = 4;
   localparam int FRAME_HOLD = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   controle_matriz_if #(.ROWS(ROWS), .FRAMES(FRAMES)) bus ();

   controle_matriz #(
      .SCAN_DIV   (SCAN_DIV),
      .ROWS       (ROWS),
      .FRAMES     (FRAMES),
      .FRAME_HOLD (FRAME_HOLD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] c, input logic [6:0] l,
                          input logic [1:0] q, input logic b, input logic t);
      check({tag, ".contador"},   32'(bus.contador),   32'(c));
      check({tag, ".linhas"},     32'(bus.linhas),     32'(l));
      check({tag, ".quadro_sel"}, 32'(bus.quadro_sel), 32'(q));
      check({tag, ".blank"},      32'(bus.blank),      32'(b));
      check({tag, ".frame_tick"}, 32'(bus.frame_tick), 32'(t));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] exp_row;
      logic [6:0] exp_lin;
      logic [1:0] exp_q;
      logic       exp_bl;
      logic       exp_tick;

      rst_n      = 1'b0;
      bus.en     = 1'b0;
      bus.pausa  = 1'b0;
      bus.avanca = 1'b0;
      #12;
      chk_all("reset", 3'd0, 7'h7F, 2'd0, 1'b1, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      chk_all("idle10", 3'd0, 7'h7F, 2'd0, 1'b1, 1'b0);

      // Edge N: en sampled, still blank; scanning starts after it.
      bus.en = 1'b1;
      tick();
      chk_all("start", 3'd0, 7'h7F, 2'd0, 1'b1, 1'b0);

      // Steps at 56/112/168/224 are auto; 280/340/400 are avanca while paused,
      // 461 is avanca together with pausa release, 476 is auto from frozen scan=1, 532 auto.
      exp_q = 2'd0;
      for (int k = 1; k <= 549; k++) begin
         tick();
         exp_tick = 1'b0;
         if (k == 56 || k == 112 || k == 168 || k == 224 || k == 280 || k == 340 ||
             k == 400 || k == 461 || k == 476 || k == 532) begin
            exp_tick = 1'b1;
            exp_q    = exp_q + 2'd1;
         end
         exp_row = 3'((k / 4) % 7);
         exp_bl  = 1'b0;
`ifdef MATRIZ_BLANK_GUARD_EN
         exp_bl  = ((k % 4) == 0);
`endif
         exp_lin = exp_bl ? 7'h7F : (7'h7F & ~(7'h01 << exp_row));
         chk_all($sformatf("run%0d", k), exp_row, exp_lin, exp_q, exp_bl, exp_tick);

         bus.avanca = (k == 99 || k == 279 || k == 339 || k == 399 || k == 460);
         if (k == 260) bus.pausa = 1'b1;
         if (k == 460) bus.pausa = 1'b0;
         if (k == 549) bus.en = 1'b0;
      end
      bus.avanca = 1'b0;

      // en dropped mid-row with contador=4, quadro_sel=2.
      tick();
      chk_all("disable", 3'd0, 7'h7F, 2'd0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      chk_all("idle_again", 3'd0, 7'h7F, 2'd0, 1'b1, 1'b0);

      // Restart from zero; avanca is ignored while idle.
      bus.en     = 1'b1;
      bus.avanca = 1'b1;
      tick();
      chk_all("restart", 3'd0, 7'h7F, 2'd0, 1'b1, 1'b0);
      bus.avanca = 1'b0;
      tick();
      chk_all("restart_row0", 3'd0, 7'h7E, 2'd0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      chk_all("restart_row1", 3'd1, 7'h7D, 2'd0, 1'b0, 1'b0);

      // Asynchronous reset away from any clock edge.
      #3;
      rst_n = 1'b0;
      #1;
      chk_all("async_reset", 3'd0, 7'h7F, 2'd0, 1'b1, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      chk_all("post_reset", 3'd0, 7'h7F, 2'd0, 1'b1, 1'b0);
      tick();
      chk_all("post_reset_row0", 3'd0, 7'h7E, 2'd0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
